apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB initiator driving the team's APB slaves.
- Converts a simple valid/ready command interface (address, direction, write data) into APB SETUP/ACCESS transfers with pready wait states.
- Returns a one-cycle response pulse carrying read data.
- Sits between the local controller/testbench sequencer and the APB bus; one outstanding transfer at a time.

Parameters:
addrWidth, 8, width of cmd_addr and paddr
dataWidth, 32, width of write/read data
RDATA_LATE, 0, 1 = capture prdata one cycle after the ACCESS cycle completes (for slaves registering prdata at end of ACCESS); 0 = capture in the completing ACCESS cycle
TIMEOUT_CYCLES, 16, ACCESS wait-state limit; used only with APB_TIMEOUT_EN

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  addrWidth  transfer address
cmd_wdata  in  dataWidth  write data
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_rdata  out  dataWidth  read data, valid with rsp_valid on reads, 0 on writes
rsp_timeout  out  1  transfer aborted by timeout, qualified by rsp_valid
paddr  out  addrWidth  APB address
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  dataWidth  APB write data
pready  in  1  APB ready
prdata  in  dataWidth  APB read data

Behaviour:
- Reset (rst high at posedge) values: state IDLE; psel, penable, pwrite, rsp_valid and rsp_timeout = 0; paddr, pwdata and rsp_rdata = 0; wait counter = 0.
- Reset mid-transfer aborts with no response; the bus returns to IDLE on the next edge.
- cmd_ready = 1 only in IDLE, combinational from state.
- States:
  - IDLE: psel=0, penable=0. On accept, latch addr/write/wdata into paddr/pwrite/pwdata; go to SETUP.
  - SETUP: psel=1, penable=0; always go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1.
    - pready=0: stay (wait state).
    - pready=1: transfer completes at that edge.
    - Write, or read with RDATA_LATE=0: go to IDLE; rsp_valid=1 next cycle; reads capture prdata into rsp_rdata at that edge.
    - Read with RDATA_LATE=1: go to RCAPT.
  - RCAPT (RDATA_LATE=1 reads only): psel=0, penable=0; capture prdata at the edge ending this cycle; go to IDLE with rsp_valid=1.
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS and hold their last value in IDLE.
- Latency, command accepted at edge N, no wait states:
  - SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3.
  - Each wait state adds 1 cycle.
  - RDATA_LATE=1 reads add 1 more cycle.
- Back-to-back: rsp_valid and cmd_ready are both high in the same IDLE cycle, so a new command can be accepted there. Minimum 3 cycles per transfer.
- rsp_valid is high for exactly one cycle. rsp_rdata holds its value until the next read completion or reset.
- cmd_* are ignored outside IDLE.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - Counter increments each ACCESS cycle with pready=0 and clears on SETUP.
  - When the count equals TIMEOUT_CYCLES while pready=0, the transfer is abandoned: IDLE next edge (psel=penable=0), rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 in the same cycle as the limit completes the transfer normally.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout is tied 0.

Test Plan:
- Reset: hold rst 2 cycles mid-ACCESS -> all outputs 0, no rsp_valid, cmd_ready=1 after release.
- Write addr 0x10, data 0xDEADBEEF, pready=1 -> SETUP (psel=1, penable=0) then ACCESS (penable=1) with paddr=0x10, pwrite=1, pwdata=0xDEADBEEF; rsp_valid pulse 3 cycles after accept, rsp_rdata=0.
- Read addr 0x10, pready low 3 ACCESS cycles, prdata=0xDEADBEEF when pready=1, RDATA_LATE=0 -> paddr stable throughout, rsp_valid 6 cycles after accept, rsp_rdata=0xDEADBEEF.
- RDATA_LATE=1 read, prdata=0x12345678 presented the cycle after ACCESS -> rsp_rdata=0x12345678, rsp_valid 4 cycles after accept.
- cmd_valid held high with 4 commands (W 0x01, R 0x01, W 0xFF, R 0xFF) -> accepts every 3 cycles; no idle gaps beyond IDLE cycle; 4 rsp_valid pulses in order.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 wait cycles; rsp_valid=1 and rsp_timeout=1; next command proceeds normally with rsp_timeout=0.

Source files
------------

// File: rtl/apb_master_if.sv
// APB master bus bundle: command/response handshake towards the local
// controller plus the APB signals towards the slave.
// master modport = apb_master side, slave modport = sequencer/APB-slave side.
interface apb_master_if #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [addrWidth-1:0] cmd_addr;
    logic [dataWidth-1:0] cmd_wdata;
    logic                 rsp_valid;
    logic [dataWidth-1:0] rsp_rdata;
    logic                 rsp_timeout;
    logic [addrWidth-1:0] paddr;
    logic                 pwrite;
    logic                 psel;
    logic                 penable;
    logic [dataWidth-1:0] pwdata;
    logic                 pready;
    logic [dataWidth-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  paddr, pwrite, psel, penable, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB initiator: turns one valid/ready command into an APB SETUP/ACCESS
// transfer (honouring pready wait states) and returns a one-cycle response.
// One transfer outstanding at a time; cmd_ready is high only in IDLE.
// Optional build macro APB_TIMEOUT_EN: abandons an ACCESS phase after
// TIMEOUT_CYCLES wait states and flags it with rsp_timeout.
module apb_master #(
    parameter int addrWidth      = 8,
    parameter int dataWidth      = 32,
    parameter int RDATA_LATE     = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RCAPT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [addrWidth-1:0] r_paddr;
    logic                 r_pwrite;
    logic [dataWidth-1:0] r_pwdata;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_rsp_valid;
    logic [dataWidth-1:0] r_rsp_rdata;
    logic                 r_rsp_timeout;
    logic                 w_timeout;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Limit reached on a cycle where the slave is still not ready.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES)) && !bus.pready;
`else
    // Without the timeout build the limit is meaningless; ACCESS waits forever.
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.paddr       = r_paddr;
    assign bus.pwrite      = r_pwrite;
    assign bus.pwdata      = r_pwdata;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_timeout = r_rsp_timeout;

    // Transfer sequencer: FSM state, registered APB drive and response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt    <= '0;
`endif
        end else begin
            // Response is a single-cycle pulse unless a branch below raises it.
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        // Address/direction/data stay frozen until the next accept.
                        r_paddr   <= bus.cmd_addr;
                        r_pwrite  <= bus.cmd_write;
                        r_pwdata  <= bus.cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= S_SETUP;
                    end else begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_penable  <= 1'b1;
                    r_state    <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (bus.pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (!r_pwrite && (RDATA_LATE != 0)) begin
                            // Slave registers prdata at end of ACCESS: sample next cycle.
                            r_state <= S_RCAPT;
                        end else begin
                            r_state     <= S_IDLE;
                            r_rsp_valid <= 1'b1;
                            // Writes report zero read data.
                            r_rsp_rdata <= r_pwrite ? '0 : bus.prdata;
                        end
                    end else if (w_timeout) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= S_IDLE;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                    end else begin
`ifdef APB_TIMEOUT_EN
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
`endif
                    end
                end
                S_RCAPT: begin
                    r_rsp_rdata <= bus.prdata;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master. DUT u_dut0 uses RDATA_LATE=0 with a
// memory-backed APB slave model with programmable wait states; DUT u_dut1
// uses RDATA_LATE=1 with a slave that presents prdata one cycle late.
// Expected responses are queued when commands are issued and popped when
// rsp_valid appears. Timeout steps run only when APB_TIMEOUT_EN is defined.
module tb_apb_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        int          lat;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t exp_q[$];
    int   acc_q[$];
    int   acc_log[$];

    apb_master_if #(.addrWidth(AW), .dataWidth(DW)) bus0 ();
    apb_master_if #(.addrWidth(AW), .dataWidth(DW)) bus1 ();

    apb_master #(.addrWidth(AW), .dataWidth(DW), .RDATA_LATE(0), .TIMEOUT_CYCLES(TO))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    apb_master #(.addrWidth(AW), .dataWidth(DW), .RDATA_LATE(1), .TIMEOUT_CYCLES(TO))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model for DUT0 ----------------
    int          s0_waits = 0;   // wait states per transfer, -1 = never ready
    int          s0_wcnt  = 0;
    logic [31:0] s0_mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) s0_mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (bus0.psel && bus0.penable && !bus0.pready) s0_wcnt <= s0_wcnt + 1;
        else s0_wcnt <= 0;
        if (bus0.psel && bus0.penable && bus0.pready && bus0.pwrite)
            s0_mem[bus0.paddr] <= bus0.pwdata;
    end

    assign bus0.pready = (s0_waits >= 0) && (s0_wcnt >= s0_waits);
    assign bus0.prdata = (bus0.psel && bus0.penable && bus0.pready) ? s0_mem[bus0.paddr] : 32'hBAD0_BAD0;

    // ---------------- late-data slave model for DUT1 ----------------
    logic s1_late = 1'b0;
    always @(posedge clk) s1_late <= bus1.psel && bus1.penable && bus1.pready;
    assign bus1.pready = 1'b1;
    assign bus1.prdata = s1_late ? 32'h1234_5678 : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor / scoreboard for DUT0 ----------------
    logic        prev_psel = 1'b0;
    logic        prev_rsp  = 1'b0;
    logic [7:0]  cur_addr  = 8'h0;
    logic        cur_write = 1'b0;
    logic [31:0] cur_wdata = 32'h0;
    exp_t        mon_e;
    int          mon_a;

    always @(negedge clk) begin
        if (rst) begin
            prev_psel = 1'b0;
            prev_rsp  = 1'b0;
        end else begin
            if (bus0.penable) begin
                check("penable_needs_psel", bus0.psel, 1'b1);
                check("access_after_setup", prev_psel, 1'b1);
            end
            if (bus0.psel && !bus0.penable) check("setup_one_cycle", prev_psel, 1'b0);
            if (bus0.psel) begin
                check("paddr_stable", bus0.paddr, cur_addr);
                check("pwrite_stable", bus0.pwrite, cur_write);
                check("pwdata_stable", bus0.pwdata, cur_wdata);
            end
            if (bus0.rsp_valid) begin
                check("rsp_single_cycle", prev_rsp, 1'b0);
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("rsp_unexpected", bus0.rsp_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_a = acc_q.pop_front();
                    check("rsp_latency", cyc - mon_a, mon_e.lat);
                    if (mon_e.chk_rd) check("rsp_rdata", bus0.rsp_rdata, mon_e.rdata);
                    check("rsp_timeout", bus0.rsp_timeout, mon_e.tmo);
                end
            end
            if (bus0.cmd_valid && bus0.cmd_ready) begin
                acc_q.push_back(cyc);
                acc_log.push_back(cyc);
                cur_addr  = bus0.cmd_addr;
                cur_write = bus0.cmd_write;
                cur_wdata = bus0.cmd_wdata;
            end
            prev_psel = bus0.psel;
            prev_rsp  = bus0.rsp_valid;
        end
    end

    // Drive one command on DUT0 and queue its expected response; returns
    // just after the accepting edge with cmd_valid still asserted.
    task automatic send0(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input int waits, input int lat, input logic chk_rd,
                         input logic [31:0] erd, input logic tmo);
        exp_t e;
        logic took;
        int   b;
        e.lat = lat; e.chk_rd = chk_rd; e.rdata = erd; e.tmo = tmo;
        exp_q.push_back(e);
        s0_waits       = waits;
        bus0.cmd_write = wr;
        bus0.cmd_addr  = a;
        bus0.cmd_wdata = d;
        bus0.cmd_valid = 1'b1;
        took = 1'b0;
        b    = 0;
        while (!took && b < 40) begin
            took = bus0.cmd_ready;
            @(posedge clk); #1;
            b++;
        end
        check("accept_bound", took, 1'b1);
    endtask

    task automatic drain0();
        int b;
        b = 0;
        bus0.cmd_valid = 1'b0;
        while (exp_q.size() != 0 && b < 60) begin
            @(posedge clk); #1;
            b++;
        end
        check("drain_bound", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_psel"}, bus0.psel, 1'b0);
        check({tag, "_penable"}, bus0.penable, 1'b0);
        check({tag, "_pwrite"}, bus0.pwrite, 1'b0);
        check({tag, "_paddr"}, bus0.paddr, 8'h00);
        check({tag, "_pwdata"}, bus0.pwdata, 32'h0);
        check({tag, "_rsp_valid"}, bus0.rsp_valid, 1'b0);
        check({tag, "_rsp_timeout"}, bus0.rsp_timeout, 1'b0);
        check({tag, "_rsp_rdata"}, bus0.rsp_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = 8'h0; bus0.cmd_wdata = 32'h0;
        bus1.cmd_valid = 1'b0; bus1.cmd_write = 1'b0; bus1.cmd_addr = 8'h0; bus1.cmd_wdata = 32'h0;

        // Power-on reset
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check_reset_vals("por");
        rst = 1'b0;
        @(posedge clk); #1;
        check("por_cmd_ready", bus0.cmd_ready, 1'b1);

        // Single write, no wait states
        send0(1'b1, 8'h10, 32'hDEAD_BEEF, 0, 3, 1'b1, 32'h0, 1'b0);
        drain0();
        check("wr_paddr_hold", bus0.paddr, 8'h10);
        check("wr_pwrite_hold", bus0.pwrite, 1'b1);
        check("wr_idle_psel", bus0.psel, 1'b0);

        // Read with 3 wait states
        send0(1'b0, 8'h10, 32'h0, 3, 6, 1'b1, 32'hDEAD_BEEF, 1'b0);
        drain0();
        check("rd_rdata_hold", bus0.rsp_rdata, 32'hDEAD_BEEF);

        // Back-to-back stream with cmd_valid held high
        base = acc_log.size();
        send0(1'b1, 8'h01, 32'hA5A5_0001, 0, 3, 1'b0, 32'h0, 1'b0);
        send0(1'b0, 8'h01, 32'h0, 0, 3, 1'b1, 32'hA5A5_0001, 1'b0);
        send0(1'b1, 8'hFF, 32'h0F0F_F0F0, 0, 3, 1'b0, 32'h0, 1'b0);
        send0(1'b0, 8'hFF, 32'h0, 0, 3, 1'b1, 32'h0F0F_F0F0, 1'b0);
        drain0();
        check("b2b_accepts", acc_log.size() - base, 4);
        for (int i = 1; i < 4; i++) check("b2b_spacing", acc_log[base + i] - acc_log[base + i - 1], 3);
        repeat (3) begin @(posedge clk); #1; end
        check("b2b_rdata_hold", bus0.rsp_rdata, 32'h0F0F_F0F0);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: transfer abandoned with rsp_timeout
        send0(1'b1, 8'h20, 32'h5555_AAAA, -1, 3 + TO, 1'b1, 32'h0, 1'b1);
        drain0();
        check("tmo_idle_psel", bus0.psel, 1'b0);
        send0(1'b0, 8'h10, 32'h0, 0, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);
        drain0();
`endif

        // Reset in the middle of a stalled ACCESS phase
        send0(1'b1, 8'h44, 32'h1111_2222, -1, 3, 1'b0, 32'h0, 1'b0);
        bus0.cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_psel", bus0.psel, 1'b1);
        check("mid_penable", bus0.penable, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        check_reset_vals("rst1");
        @(posedge clk); #1;
        check_reset_vals("rst2");
        rst = 1'b0;
        s0_waits = 0;
        @(posedge clk); #1;
        check("rst_cmd_ready", bus0.cmd_ready, 1'b1);
        check("rst_psel", bus0.psel, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        check("rst_no_rsp", bus0.rsp_valid, 1'b0);

        // RDATA_LATE=1 DUT: read then write
        bus1.cmd_write = 1'b0; bus1.cmd_addr = 8'h33; bus1.cmd_wdata = 32'h0; bus1.cmd_valid = 1'b1;
        check("late_cmd_ready", bus1.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
        check("late_setup_psel", bus1.psel, 1'b1);
        n = 1;
        while (!bus1.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("late_rd_latency", n, 4);
        check("late_rd_rdata", bus1.rsp_rdata, 32'h1234_5678);
        check("late_rd_timeout", bus1.rsp_timeout, 1'b0);
        @(posedge clk); #1;
        check("late_rsp_pulse", bus1.rsp_valid, 1'b0);

        bus1.cmd_write = 1'b1; bus1.cmd_addr = 8'h34; bus1.cmd_wdata = 32'hCAFE_F00D; bus1.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
        n = 1;
        while (!bus1.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("late_wr_latency", n, 3);
        check("late_wr_pwdata", bus1.pwdata, 32'hCAFE_F00D);

        repeat (2) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
